// File: rtl/membus_pkg.sv
// Shared types for the MemBus arbiter slice.
//   req_id_t     : which pipeline port issued a cmd (ibus or dbus)
//   membus_cmd_t : cmd payload at the default 32-bit widths
//   membus_rsp_t : rsp payload at the default 32-bit widths
//   other_id()   : the requester that is not the given one
package membus_pkg;

  localparam int unsigned MEMBUS_ADDR_W = 32;
  localparam int unsigned MEMBUS_DATA_W = 32;

  typedef enum logic {
    REQ_IBUS = 1'b0,
    REQ_DBUS = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [MEMBUS_ADDR_W-1:0]   address;
    logic                       write;
    logic [MEMBUS_DATA_W-1:0]   wdata;
    logic [MEMBUS_DATA_W/8-1:0] wmask;
  } membus_cmd_t;

  typedef struct packed {
    logic [MEMBUS_DATA_W-1:0] rdata;
  } membus_rsp_t;

  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_IBUS) ? REQ_DBUS : REQ_IBUS;
  endfunction

endpackage

// File: rtl/membus_if.sv
// One MemBus port: cmd channel (address/write/wdata/wmask) and rsp channel
// (rdata), each with a valid/ready handshake.
//   master : issues cmds, accepts rsps (pipeline side, or the arbiter toward memory)
//   slave  : accepts cmds, returns rsps
interface membus_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_WIDTH-1:0]   cmd_payload_address;
  logic                    cmd_payload_write;
  logic [DATA_WIDTH-1:0]   cmd_payload_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_payload_wmask;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_payload_rdata;

  modport master (
    output cmd_valid, cmd_payload_address, cmd_payload_write,
           cmd_payload_wdata, cmd_payload_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_rdata
  );

  modport slave (
    input  cmd_valid, cmd_payload_address, cmd_payload_write,
           cmd_payload_wdata, cmd_payload_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_rdata
  );
endinterface

// File: rtl/membus_id_fifo.sv
// In-order FIFO of requester IDs for reads issued but not yet answered.
//   clk, reset_n : clock, async active-low reset
//   push_i/push_id_i : enqueue an ID (ignored when full)
//   pop_i        : dequeue the head (ignored when empty)
//   head_o       : oldest outstanding ID
//   count_o      : number of entries
//   full_o/empty_o : occupancy flags
module membus_id_fifo
  import membus_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           push_i,
  input  req_id_t        push_id_i,
  input  logic           pop_i,
  output req_id_t        head_o,
  output logic [PTR_W:0] count_o,
  output logic           full_o,
  output logic           empty_o
);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  req_id_t          slot_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = slot_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q > 0.
  always_ff @(posedge clk) begin
    if (push_ok) slot_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/membus_arbiter.sv
// Shares one MemBus port between the pipeline ibus and dbus.
//   clk, reset_n   : clock, async active-low reset
//   ibus (slave)   : instruction fetch port (write fields ignored)
//   dbus (slave)   : load/store port
//   mem  (master)  : shared memory/interconnect port
//   rsp_unexpected : one-cycle pulse after a rsp arrives with no read outstanding
// Cmds are arbitrated round-robin with the grant held while stalled; read
// issuers are queued in order so each rsp returns to the port that asked.
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  membus_if.slave  ibus,
  membus_if.slave  dbus,
  membus_if.master mem,
  output logic     rsp_unexpected
);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

  req_id_t lock_id_q, lock_id_d;
  logic    lock_q, lock_d;
  req_id_t last_grant_q, last_grant_d;
  logic    unexpected_q, unexpected_d;

  logic    fifo_full, fifo_empty;
  req_id_t fifo_head;
  logic [PTR_W:0] fifo_count;

  logic    ibus_elig, dbus_elig, lock_hold;
  logic    grant_valid;
  req_id_t grant_id;
  logic    cmd_fire, push, pop;

  logic [ADDR_WIDTH-1:0]   sel_address;
  logic                    sel_write;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_wmask;

  // ibus only fetches, so its write-side payload is never forwarded.
  logic unused_inputs;
  assign unused_inputs = ^{ibus.cmd_payload_write, ibus.cmd_payload_wdata,
                           ibus.cmd_payload_wmask, fifo_count};

  assign ibus_elig = ibus.cmd_valid && !fifo_full;
  assign dbus_elig = dbus.cmd_valid && (dbus.cmd_payload_write || !fifo_full);
  // A stalled grant stays put only while its owner keeps valid asserted.
  assign lock_hold = lock_q && ((lock_id_q == REQ_IBUS) ? ibus.cmd_valid : dbus.cmd_valid);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_IBUS;
    if (lock_hold) begin
      grant_valid = 1'b1;
      grant_id    = lock_id_q;
    end else if (ibus_elig && dbus_elig) begin
      grant_valid = 1'b1;
      grant_id    = other_id(last_grant_q);
    end else if (ibus_elig) begin
      grant_valid = 1'b1;
      grant_id    = REQ_IBUS;
    end else if (dbus_elig) begin
      grant_valid = 1'b1;
      grant_id    = REQ_DBUS;
    end
  end

  always_comb begin
    sel_address = ibus.cmd_payload_address;
    sel_write   = 1'b0;
    sel_wdata   = '0;
    sel_wmask   = '0;
    if (grant_id == REQ_DBUS) begin
      sel_address = dbus.cmd_payload_address;
      sel_write   = dbus.cmd_payload_write;
      sel_wdata   = dbus.cmd_payload_wdata;
      sel_wmask   = dbus.cmd_payload_wmask;
    end
  end

  assign mem.cmd_valid           = grant_valid;
  assign mem.cmd_payload_address = sel_address;
  assign mem.cmd_payload_write   = sel_write;
  assign mem.cmd_payload_wdata   = sel_wdata;
  assign mem.cmd_payload_wmask   = sel_wmask;
  assign ibus.cmd_ready = grant_valid && (grant_id == REQ_IBUS) && mem.cmd_ready;
  assign dbus.cmd_ready = grant_valid && (grant_id == REQ_DBUS) && mem.cmd_ready;

  assign cmd_fire = grant_valid && mem.cmd_ready;
  assign push     = cmd_fire && !sel_write;

  always_comb begin
    ibus.rsp_valid = 1'b0;
    dbus.rsp_valid = 1'b0;
    mem.rsp_ready  = 1'b0;
    if (fifo_empty) begin
      // Nothing outstanding: swallow the stray rsp so the bus cannot wedge.
      mem.rsp_ready = mem.rsp_valid;
    end else if (fifo_head == REQ_IBUS) begin
      ibus.rsp_valid = mem.rsp_valid;
      mem.rsp_ready  = ibus.rsp_ready;
    end else begin
      dbus.rsp_valid = mem.rsp_valid;
      mem.rsp_ready  = dbus.rsp_ready;
    end
  end

  assign ibus.rsp_payload_rdata = mem.rsp_payload_rdata;
  assign dbus.rsp_payload_rdata = mem.rsp_payload_rdata;

  assign pop          = !fifo_empty && mem.rsp_valid && mem.rsp_ready;
  assign unexpected_d = fifo_empty && mem.rsp_valid;
  assign lock_d       = grant_valid && !mem.cmd_ready;
  assign lock_id_d    = grant_id;
  assign last_grant_d = cmd_fire ? grant_id : last_grant_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q       <= 1'b0;
      lock_id_q    <= REQ_IBUS;
      last_grant_q <= REQ_DBUS;
      unexpected_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      unexpected_q <= unexpected_d;
    end
  end

  assign rsp_unexpected = unexpected_q;

  membus_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (push),
    .push_id_i (grant_id),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_membus_arbiter.sv
module tb_membus_arbiter;
  import membus_pkg::*;

  typedef struct packed {
    req_id_t     id;
    membus_cmd_t cmd;
  } exp_cmd_t;

  logic clk;
  logic reset_n;
  logic rsp_unexpected;

  membus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ibus_if ();
  membus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dbus_if ();
  membus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

  membus_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ibus           (ibus_if),
    .dbus           (dbus_if),
    .mem            (mem_if),
    .rsp_unexpected (rsp_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_cmd_t    exp_cmd_q [$];
  logic [31:0] exp_irsp_q [$];
  logic [31:0] exp_drsp_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic exp_cmd(input req_id_t id, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] m);
    exp_cmd_t e;
    e.id          = id;
    e.cmd.address = a;
    e.cmd.write   = w;
    e.cmd.wdata   = wd;
    e.cmd.wmask   = m;
    exp_cmd_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every fire on the shared cmd channel or on either
  // rsp channel is matched against the oldest expected entry.
  exp_cmd_t    mon_act, mon_exp;
  logic [31:0] mon_rd;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_if.cmd_valid && mem_if.cmd_ready) begin
        mon_act.id          = dbus_if.cmd_ready ? REQ_DBUS : REQ_IBUS;
        mon_act.cmd.address = mem_if.cmd_payload_address;
        mon_act.cmd.write   = mem_if.cmd_payload_write;
        mon_act.cmd.wdata   = mem_if.cmd_payload_wdata;
        mon_act.cmd.wmask   = mem_if.cmd_payload_wmask;
        chk("cmd_ready_onehot", 128'({ibus_if.cmd_ready, dbus_if.cmd_ready}), 128'(2'b01 << (mon_act.id == REQ_IBUS)));
        if (exp_cmd_q.size() == 0) chk("cmd_extra", 128'(mon_act), 128'(0));
        else begin
          mon_exp = exp_cmd_q.pop_front();
          chk("cmd_fire", 128'(mon_act), 128'(mon_exp));
        end
      end
      if (ibus_if.rsp_valid && ibus_if.rsp_ready) begin
        if (exp_irsp_q.size() == 0) chk("irsp_extra", 128'(ibus_if.rsp_payload_rdata), 128'(0));
        else begin
          mon_rd = exp_irsp_q.pop_front();
          chk("irsp_data", 128'(ibus_if.rsp_payload_rdata), 128'(mon_rd));
        end
      end
      if (dbus_if.rsp_valid && dbus_if.rsp_ready) begin
        if (exp_drsp_q.size() == 0) chk("drsp_extra", 128'(dbus_if.rsp_payload_rdata), 128'(0));
        else begin
          mon_rd = exp_drsp_q.pop_front();
          chk("drsp_data", 128'(dbus_if.rsp_payload_rdata), 128'(mon_rd));
        end
      end
    end
  end

  initial begin
    // ibus write-side fields carry junk; the arbiter must drive zeros in their place
    ibus_if.cmd_valid           = 1'b0;
    ibus_if.cmd_payload_address = '0;
    ibus_if.cmd_payload_write   = 1'b1;
    ibus_if.cmd_payload_wdata   = 32'hFFFF_FFFF;
    ibus_if.cmd_payload_wmask   = 4'hF;
    ibus_if.rsp_ready           = 1'b1;
    dbus_if.cmd_valid           = 1'b0;
    dbus_if.cmd_payload_address = '0;
    dbus_if.cmd_payload_write   = 1'b0;
    dbus_if.cmd_payload_wdata   = '0;
    dbus_if.cmd_payload_wmask   = '0;
    dbus_if.rsp_ready           = 1'b1;
    mem_if.cmd_ready            = 1'b0;
    mem_if.rsp_valid            = 1'b0;
    mem_if.rsp_payload_rdata    = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;

    // Reset state
    mid();
    chk("rst_outputs", 128'({mem_if.cmd_valid, ibus_if.cmd_ready, dbus_if.cmd_ready,
                             ibus_if.rsp_valid, dbus_if.rsp_valid, mem_if.rsp_ready, rsp_unexpected}), 128'(0));
    chk("rst_count", 128'(dut.fifo_count), 128'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // Round-robin: ibus reads vs dbus writes, tie won by ibus first
    exp_cmd(REQ_IBUS, 32'h10, 1'b0, 32'h0, 4'h0);
    exp_cmd(REQ_DBUS, 32'h20, 1'b1, 32'hAA, 4'h3);
    exp_cmd(REQ_IBUS, 32'h10, 1'b0, 32'h0, 4'h0);
    exp_cmd(REQ_DBUS, 32'h20, 1'b1, 32'hAA, 4'h3);
    ibus_if.cmd_valid = 1'b1; ibus_if.cmd_payload_address = 32'h10;
    dbus_if.cmd_valid = 1'b1; dbus_if.cmd_payload_address = 32'h20;
    dbus_if.cmd_payload_write = 1'b1; dbus_if.cmd_payload_wdata = 32'hAA; dbus_if.cmd_payload_wmask = 4'h3;
    mem_if.cmd_ready = 1'b1;
    repeat (4) tick();
    ibus_if.cmd_valid = 1'b0; dbus_if.cmd_valid = 1'b0;
    exp_irsp_q.push_back(32'h11);
    exp_irsp_q.push_back(32'h22);
    mem_if.rsp_valid = 1'b1; mem_if.rsp_payload_rdata = 32'h11;
    tick();
    mem_if.rsp_payload_rdata = 32'h22;
    tick();
    mem_if.rsp_valid = 1'b0;
    mid();
    chk("rr_count", 128'(dut.fifo_count), 128'(0));
    tick();

    // Single ibus read, rsp two cycles later
    exp_cmd(REQ_IBUS, 32'h100, 1'b0, 32'h0, 4'h0);
    exp_irsp_q.push_back(32'hDEADBEEF);
    ibus_if.cmd_valid = 1'b1; ibus_if.cmd_payload_address = 32'h100;
    tick();
    ibus_if.cmd_valid = 1'b0;
    tick();
    mem_if.rsp_valid = 1'b1; mem_if.rsp_payload_rdata = 32'hDEADBEEF;
    mid();
    chk("rd_route", 128'({ibus_if.rsp_valid, dbus_if.rsp_valid}), 128'(2'b10));
    chk("rd_count_busy", 128'(dut.fifo_count), 128'(1));
    tick();
    mem_if.rsp_valid = 1'b0;
    mid();
    chk("rd_count_done", 128'(dut.fifo_count), 128'(0));
    tick();

    // dbus store stalled 3 cycles with ibus also requesting
    exp_cmd(REQ_DBUS, 32'h200, 1'b1, 32'h12345678, 4'hF);
    exp_cmd(REQ_IBUS, 32'h210, 1'b0, 32'h0, 4'h0);
    exp_irsp_q.push_back(32'h33);
    mem_if.cmd_ready = 1'b0;
    ibus_if.cmd_valid = 1'b1; ibus_if.cmd_payload_address = 32'h210;
    dbus_if.cmd_valid = 1'b1; dbus_if.cmd_payload_address = 32'h200;
    dbus_if.cmd_payload_write = 1'b1; dbus_if.cmd_payload_wdata = 32'h12345678; dbus_if.cmd_payload_wmask = 4'hF;
    for (int unsigned i = 0; i < 3; i++) begin
      mid();
      chk("stall_payload", 128'({mem_if.cmd_valid, mem_if.cmd_payload_address, mem_if.cmd_payload_write,
                                 mem_if.cmd_payload_wdata, mem_if.cmd_payload_wmask}),
          128'({1'b1, 32'h200, 1'b1, 32'h12345678, 4'hF}));
      chk("stall_ibus_ready", 128'(ibus_if.cmd_ready), 128'(0));
      chk("stall_count", 128'(dut.fifo_count), 128'(0));
      tick();
    end
    mem_if.cmd_ready = 1'b1;
    tick();
    dbus_if.cmd_valid = 1'b0;
    tick();
    ibus_if.cmd_valid = 1'b0;
    mem_if.rsp_valid = 1'b1; mem_if.rsp_payload_rdata = 32'h33;
    tick();
    mem_if.rsp_valid = 1'b0;

    // Lock holds ibus even though a tie would now favour dbus
    exp_cmd(REQ_IBUS, 32'h300, 1'b0, 32'h0, 4'h0);
    exp_cmd(REQ_DBUS, 32'h400, 1'b1, 32'h55, 4'h1);
    exp_irsp_q.push_back(32'h44);
    mem_if.cmd_ready = 1'b0;
    ibus_if.cmd_valid = 1'b1; ibus_if.cmd_payload_address = 32'h300;
    tick();
    dbus_if.cmd_valid = 1'b1; dbus_if.cmd_payload_address = 32'h400;
    dbus_if.cmd_payload_write = 1'b1; dbus_if.cmd_payload_wdata = 32'h55; dbus_if.cmd_payload_wmask = 4'h1;
    for (int unsigned i = 0; i < 2; i++) begin
      mid();
      chk("lock_addr", 128'(mem_if.cmd_payload_address), 128'(32'h300));
      tick();
    end
    mem_if.cmd_ready = 1'b1;
    tick();
    ibus_if.cmd_valid = 1'b0;
    tick();
    dbus_if.cmd_valid = 1'b0;
    mem_if.rsp_valid = 1'b1; mem_if.rsp_payload_rdata = 32'h44;
    tick();
    mem_if.rsp_valid = 1'b0;

    // Locked requester drops valid: lock clears, dbus granted at once
    exp_cmd(REQ_DBUS, 32'h510, 1'b1, 32'h5A, 4'h2);
    mem_if.cmd_ready = 1'b0;
    ibus_if.cmd_valid = 1'b1; ibus_if.cmd_payload_address = 32'h500;
    tick();
    ibus_if.cmd_valid = 1'b0;
    dbus_if.cmd_valid = 1'b1; dbus_if.cmd_payload_address = 32'h510;
    dbus_if.cmd_payload_write = 1'b1; dbus_if.cmd_payload_wdata = 32'h5A; dbus_if.cmd_payload_wmask = 4'h2;
    mid();
    chk("unlock_regrant", 128'({mem_if.cmd_valid, mem_if.cmd_payload_address}), 128'({1'b1, 32'h510}));
    tick();
    mem_if.cmd_ready = 1'b1;
    tick();
    dbus_if.cmd_valid = 1'b0;

    // Fill to MAX_OUTSTANDING, then a blocked read and a passing write
    exp_cmd(REQ_IBUS, 32'h41, 1'b0, 32'h0, 4'h0);
    exp_cmd(REQ_DBUS, 32'h42, 1'b0, 32'h0, 4'h0);
    exp_cmd(REQ_IBUS, 32'h41, 1'b0, 32'h0, 4'h0);
    exp_cmd(REQ_DBUS, 32'h42, 1'b0, 32'h0, 4'h0);
    exp_cmd(REQ_DBUS, 32'h60, 1'b1, 32'h66, 4'hC);
    exp_cmd(REQ_IBUS, 32'h50, 1'b0, 32'h0, 4'h0);
    exp_irsp_q.push_back(32'h1); exp_drsp_q.push_back(32'h2);
    exp_irsp_q.push_back(32'h3); exp_drsp_q.push_back(32'h4);
    exp_irsp_q.push_back(32'h5);
    ibus_if.cmd_valid = 1'b1; ibus_if.cmd_payload_address = 32'h41;
    dbus_if.cmd_valid = 1'b1; dbus_if.cmd_payload_address = 32'h42;
    dbus_if.cmd_payload_write = 1'b0; dbus_if.cmd_payload_wdata = '0; dbus_if.cmd_payload_wmask = '0;
    repeat (4) tick();
    ibus_if.cmd_payload_address = 32'h50;
    dbus_if.cmd_payload_address = 32'h60;
    dbus_if.cmd_payload_write = 1'b1; dbus_if.cmd_payload_wdata = 32'h66; dbus_if.cmd_payload_wmask = 4'hC;
    mid();
    chk("full_count", 128'(dut.fifo_count), 128'(4));
    chk("full_ibus_ready", 128'(ibus_if.cmd_ready), 128'(0));
    tick();
    dbus_if.cmd_valid = 1'b0;
    mid();
    chk("full_no_grant", 128'(mem_if.cmd_valid), 128'(0));
    tick();
    mem_if.rsp_valid = 1'b1; mem_if.rsp_payload_rdata = 32'h1;
    mid();
    chk("full_no_bypass", 128'({mem_if.cmd_valid, ibus_if.cmd_ready}), 128'(0));
    tick();
    mem_if.rsp_payload_rdata = 32'h2;
    tick();
    ibus_if.cmd_valid = 1'b0;
    mem_if.rsp_payload_rdata = 32'h3;
    tick();
    mem_if.rsp_payload_rdata = 32'h4;
    tick();
    mem_if.rsp_payload_rdata = 32'h5;
    tick();
    mem_if.rsp_valid = 1'b0;
    mid();
    chk("drain_count", 128'(dut.fifo_count), 128'(0));
    tick();

    // dbus rsp backpressure, then a stray rsp with nothing outstanding
    exp_cmd(REQ_DBUS, 32'h700, 1'b0, 32'h0, 4'h0);
    exp_drsp_q.push_back(32'h77);
    dbus_if.cmd_valid = 1'b1; dbus_if.cmd_payload_address = 32'h700;
    dbus_if.cmd_payload_write = 1'b0; dbus_if.cmd_payload_wdata = '0; dbus_if.cmd_payload_wmask = '0;
    tick();
    dbus_if.cmd_valid = 1'b0;
    dbus_if.rsp_ready = 1'b0;
    mem_if.rsp_valid = 1'b1; mem_if.rsp_payload_rdata = 32'h77;
    mid();
    chk("bp_route", 128'({mem_if.rsp_ready, ibus_if.rsp_valid, dbus_if.rsp_valid}), 128'(3'b001));
    tick();
    dbus_if.rsp_ready = 1'b1;
    mid();
    chk("bp_count_held", 128'(dut.fifo_count), 128'(1));
    tick();
    mem_if.rsp_payload_rdata = 32'h99;
    mid();
    chk("stray_drain", 128'({dut.fifo_count, mem_if.rsp_ready, ibus_if.rsp_valid, dbus_if.rsp_valid, rsp_unexpected}),
        128'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
    tick();
    mem_if.rsp_valid = 1'b0;
    mid();
    chk("stray_pulse", 128'(rsp_unexpected), 128'(1));
    tick();
    mid();
    chk("stray_pulse_end", 128'(rsp_unexpected), 128'(0));
    tick();

    // Reset with two reads outstanding discards them
    exp_cmd(REQ_IBUS, 32'h800, 1'b0, 32'h0, 4'h0);
    exp_cmd(REQ_DBUS, 32'h900, 1'b0, 32'h0, 4'h0);
    ibus_if.cmd_valid = 1'b1; ibus_if.cmd_payload_address = 32'h800;
    dbus_if.cmd_valid = 1'b1; dbus_if.cmd_payload_address = 32'h900;
    repeat (2) tick();
    ibus_if.cmd_valid = 1'b0; dbus_if.cmd_valid = 1'b0;
    mid();
    chk("pre_rst_count", 128'(dut.fifo_count), 128'(2));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 128'({dut.fifo_count, mem_if.cmd_valid, ibus_if.rsp_valid, dbus_if.rsp_valid,
                               mem_if.rsp_ready, rsp_unexpected}), 128'(0));
    tick();
    reset_n = 1'b1;
    tick();
    mem_if.rsp_valid = 1'b1; mem_if.rsp_payload_rdata = 32'hAB;
    mid();
    chk("post_rst_drop", 128'({mem_if.rsp_ready, ibus_if.rsp_valid, dbus_if.rsp_valid}), 128'(3'b100));
    tick();
    mem_if.rsp_valid = 1'b0;
    mid();
    chk("post_rst_pulse", 128'(rsp_unexpected), 128'(1));
    tick();
    tick();

    chk("cmd_q_empty", 128'(exp_cmd_q.size()), 128'(0));
    chk("irsp_q_empty", 128'(exp_irsp_q.size()), 128'(0));
    chk("drsp_q_empty", 128'(exp_drsp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
